// File: rtl/portgroup_tx_ser.sv
// rtl/portgroup_tx_ser.sv - LSB-first async serial frame transmitter for the port-group TX path
// Even-parity bit between data and stop is compiled in when `PORTGROUP_TX_SER_PARITY_EN is defined.
module portgroup_tx_ser #(
  parameter int width_p = 8,
  parameter int div_p   = 4
) (
  input  logic               main_clk_i,
  input  logic               main_rst_i,
  input  logic               regf_ctrl_ena_rval_i,
  input  logic [width_p-1:0] regf_tx_data0_rval_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int cnt_w_lp = $clog2(div_p + 1);
  localparam int idx_w_lp = $clog2(width_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(div_p - 1);
  localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(width_p - 1);

`ifdef PORTGROUP_TX_SER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic [idx_w_lp-1:0]  idx_q, idx_d;
  logic [width_p-1:0]   shift_q, shift_d;
  logic                 bit_end;
  logic                 accept;
`ifdef PORTGROUP_TX_SER_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign tx_ready_o = (state_q == S_IDLE) && regf_ctrl_ena_rval_i;
  assign accept     = tx_valid_i && tx_ready_o;
  assign bit_end    = (cnt_q == cnt_last_lp);
  assign busy_o     = (state_q != S_IDLE);

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
`ifdef PORTGROUP_TX_SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
`ifdef PORTGROUP_TX_SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_o     = 1'b1;
    done_o   = 1'b0;
`ifdef PORTGROUP_TX_SER_PARITY_EN
    parity_d = parity_q;
`endif

    // Bit-period counter only runs inside a frame; wrap is the sole advance condition.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + cnt_w_lp'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d  = regf_tx_data0_rval_i;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = S_START;
`ifdef PORTGROUP_TX_SER_PARITY_EN
          parity_d = ^regf_tx_data0_rval_i;
`endif
        end
      end
      S_START: begin
        tx_o = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_o = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + idx_w_lp'(1);
          if (idx_q == idx_last_lp) begin
`ifdef PORTGROUP_TX_SER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef PORTGROUP_TX_SER_PARITY_EN
      S_PARITY: begin
        tx_o = parity_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        tx_o = 1'b1;
        if (bit_end) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_portgroup_tx_ser.sv
// tb/tb_portgroup_tx_ser.sv - self-checking bench for portgroup_tx_ser
// Parity build selected by `PORTGROUP_TX_SER_PARITY_EN, same as the design.
module tb_portgroup_tx_ser;

  localparam int W = 8;
  localparam int D = 4;
`ifdef PORTGROUP_TX_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + 2 + PAR;
  localparam int F  = NB * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ena, valid, ready, tx, busy, done;
  logic [W-1:0] data;
  logic valid1, ready1, tx1, busy1, done1;
  logic [W-1:0] data1;

  portgroup_tx_ser #(.width_p(W), .div_p(D)) dut (
    .main_clk_i(clk), .main_rst_i(rst), .regf_ctrl_ena_rval_i(ena),
    .regf_tx_data0_rval_i(data), .tx_valid_i(valid), .tx_ready_o(ready),
    .tx_o(tx), .busy_o(busy), .done_o(done));

  portgroup_tx_ser #(.width_p(W), .div_p(1)) dut1 (
    .main_clk_i(clk), .main_rst_i(rst), .regf_ctrl_ena_rval_i(ena),
    .regf_tx_data0_rval_i(data1), .tx_valid_i(valid1), .tx_ready_o(ready1),
    .tx_o(tx1), .busy_o(busy1), .done_o(done1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference frame: element i is the line level during bit period i.
  function automatic logic [11:0] model_bits(input logic [W-1:0] d);
    logic [11:0] b;
    int ones;
    b = '1;
    ones = 0;
    b[0] = 1'b0;
    for (int i = 0; i < W; i++) begin
      b[1 + i] = ((d >> i) & 1) != 0;
      ones += ((d >> i) & 1);
    end
    if (PAR == 1) b[W + 1] = (ones % 2) == 1;
    b[NB - 1] = 1'b1;
    return b;
  endfunction

  // Table frame: seq lists data bits in transmission order, leftmost sent first.
  function automatic logic [11:0] table_bits(input logic [7:0] seq, input logic par);
    logic [11:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = seq[7 - i];
    if (PAR == 1) b[9] = par;
    return b;
  endfunction

  // Called at a negedge with the DUT idle; leaves at negedge of cycle F+1.
  task automatic frame(input logic [W-1:0] d, input logic [11:0] bits, input bit hold_valid,
                       input int drop_at, input string nm);
    int tx_err, busy_err, done_n, done_at;
    tx_err = 0; busy_err = 0; done_n = 0; done_at = -1;
    data = d;
    valid = 1'b1;
    #1 check({nm, "_ready"}, ready, 1);
    @(posedge clk);
    #1 data = ~d;
    for (int c = 1; c <= F; c++) begin
      @(negedge clk);
      if (!hold_valid) valid = 1'b0;
      if (c == drop_at) ena = 1'b0;
      if (tx !== bits[(c - 1) / D]) tx_err++;
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        done_n++;
        done_at = c;
      end
    end
    check({nm, "_tx_errs"}, tx_err, 0);
    check({nm, "_busy_errs"}, busy_err, 0);
    check({nm, "_done_count"}, done_n, 1);
    check({nm, "_done_cycle"}, done_at, F);
    @(negedge clk);
    check({nm, "_idle_busy"}, busy, 0);
    check({nm, "_idle_tx"}, tx, 1);
    check({nm, "_idle_ready"}, ready, ena);
    if (!hold_valid) valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[7];
  logic [W-1:0] dl[4];
  logic exp_s[64];
  int n_err, n_done, n_acc, rdy_err, tx_err, busy_err;
  logic acc;

  initial begin
    vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
    vecs[1] = '{8'h07, 8'b11100000, 1'b1};
    vecs[2] = '{8'h3C, 8'b00111100, 1'b0};
    vecs[3] = '{8'h01, 8'b10000000, 1'b1};
    vecs[4] = '{8'h80, 8'b00000001, 1'b1};
    vecs[5] = '{8'hFF, 8'b11111111, 1'b0};
    vecs[6] = '{8'h00, 8'b00000000, 1'b0};

    rst = 1'b1; ena = 1'b0; valid = 1'b0; data = '0;
    valid1 = 1'b0; data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready_ena0", ready, 0);
    ena = 1'b1;
    #1 check("rst_ready_ena1", ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) frame(vecs[i].data, table_bits(vecs[i].seq, vecs[i].par), 1'b0, -1, "table");

    // Enable gating: valid held with enable low must never start a frame.
    ena = 1'b0; valid = 1'b1;
    rdy_err = 0; tx_err = 0; busy_err = 0; n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready !== 1'b0) rdy_err++;
      if (tx !== 1'b1) tx_err++;
      if (busy !== 1'b0) busy_err++;
      if (done !== 1'b0) n_done++;
    end
    check("gate_ready_errs", rdy_err, 0);
    check("gate_tx_errs", tx_err, 0);
    check("gate_busy_errs", busy_err, 0);
    check("gate_done_count", n_done, 0);
    valid = 1'b0; ena = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] r;
      r = W'($urandom);
      frame(r, model_bits(r), 1'b0, -1, "rand");
    end

    // Enable dropped at cycle 10 with valid kept high.
    frame(8'h5A, model_bits(8'h5A), 1'b1, 10, "ena_drop");
    busy_err = 0; tx_err = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_err++;
      if (tx !== 1'b1) tx_err++;
    end
    check("ena_drop_no_accept_busy", busy_err, 0);
    check("ena_drop_no_accept_tx", tx_err, 0);
    valid = 1'b0; ena = 1'b1;
    @(negedge clk);

    // Reset pulse during cycle 15 of a frame.
    data = 8'hC3; valid = 1'b1;
    @(posedge clk);
    n_done = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      valid = 1'b0;
      if (done === 1'b1) n_done++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    for (int c = 0; c < 3 * D; c++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("midrst_done_count", n_done, 0);
    frame(8'h3C, model_bits(8'h3C), 1'b0, -1, "after_rst");

    // Back-to-back frames on the div_p=1 instance with data changed after each accept.
    for (int k = 0; k < 4; k++) dl[k] = W'($urandom);
    for (int k = 0; k < 4; k++) begin
      logic [11:0] b;
      b = model_bits(dl[k]);
      for (int j = 0; j < NB; j++) exp_s[k * (NB + 1) + j] = b[j];
      exp_s[k * (NB + 1) + NB] = 1'b1;
    end
    data1 = dl[0]; valid1 = 1'b1;
    n_err = 0; n_done = 0; n_acc = 0;
    for (int c = 0; c < 4 * (NB + 1); c++) begin
      if (c > 0) begin
        if (tx1 !== exp_s[c - 1]) n_err++;
        if (done1 === 1'b1) n_done++;
      end
      acc = ready1 & valid1;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        if (n_acc < 4) data1 = dl[n_acc];
        else valid1 = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_stream_errs", n_err, 0);
    check("b2b_accepts", n_acc, 4);
    check("b2b_done_count", n_done, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/portgroup_tx_ser.md
# portgroup_tx_ser

Transmit serializer sitting directly downstream of `portgroup_tx` in the port-group transmit path. Takes the register-file transmit word (`regf_tx_data0_rval_i`) and enable (`regf_ctrl_ena_rval_i`) and shifts the word out LSB-first as an asynchronous serial frame. A frame is a start bit, `width_p` data bits, an optional parity bit and a stop bit, with a programmable bit period. Returns busy and done status toward the register file.

## Interface
Parameters:
- `width_p`, 8, data word width in bits (≥1)
- `div_p`, 4, clock cycles per serial bit (≥1); bit counter width `$clog2(div_p+1)`

Ports:
- `main_clk_i`  in  1  clock
- `main_rst_i`  in  1  reset, synchronous, active-high
- `regf_ctrl_ena_rval_i`  in  1  transmitter enable (core read value)
- `regf_tx_data0_rval_i`  in  width_p  word to transmit (core read value)
- `tx_valid_i`  in  1  send request; sampled with `tx_ready_o`
- `tx_ready_o`  out  1  block can accept a request
- `tx_o`  out  1  serial line; idles high
- `busy_o`  out  1  frame in progress
- `done_o`  out  1  one-cycle pulse marking the final cycle of the stop bit

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- `tx_ready_o` = (state==IDLE) & `regf_ctrl_ena_rval_i`. This output is combinational from state and enable.
- Accept when `tx_valid_i & tx_ready_o` at a rising edge:
  - latch `regf_tx_data0_rval_i` into the shift register
  - clear the bit-period counter and the bit index
  - go to START
- Each state holds for exactly `div_p` cycles, counted by the bit-period counter (0..div_p-1).
- START: `tx_o`=0.
- DATA: `tx_o`=shift[0]. At the end of each bit period, shift right and increment the bit index. After bit index `width_p-1`, go to PARITY or STOP.
- PARITY: `tx_o` = XOR of the latched word (even parity).
- STOP: `tx_o`=1. `done_o`=1 in the last cycle of the stop period, then return to IDLE.
- `busy_o` = (state!=IDLE).
- Data input changes after acceptance have no effect on the frame in progress.
- Enable deasserted mid-frame: the frame completes normally; no new request is accepted until enable returns.
- `tx_valid_i` while not ready: ignored, not queued.
- Reset at any time, including mid-frame:
  - the next edge forces IDLE
  - `tx_o`=1 and `done_o`=0
  - counters and shift register are cleared
- Reset values: `tx_o`=1, `busy_o`=0, `done_o`=0. `tx_ready_o` follows enable.

## Timing
- Accept at edge N: `tx_o` goes low in the cycle after N and stays low for `div_p` cycles.
- Frame length F = (width_p+2)·div_p cycles, or (width_p+3)·div_p with parity.
- `done_o` is high in cycle F after acceptance, with acceptance counted as cycle 0.
- IDLE is re-entered at the edge ending the `done_o` cycle. `tx_ready_o` is high in the following cycle.
- With `tx_valid_i` held high, the minimum inter-frame gap is 1 idle-high cycle.
- `div_p`=1: each bit lasts one cycle. The counter always wraps immediately.
- Counter wrap-around at `div_p-1` is the only state/bit advance condition. It never advances early.

## Configuration
- Macro `PORTGROUP_TX_SER_PARITY_EN`:
  - defined: the PARITY state is compiled in, and an even-parity bit is sent between the last data bit and the stop bit
  - undefined: no PARITY state, no parity logic; DATA goes directly to STOP and the frame is one bit period shorter

## Test plan
- Basic frame: width_p=8, div_p=4, no parity, ena=1, data 0xA5, pulse valid 1 cycle. Required response:
  - `tx_o` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles
  - `done_o` single pulse 40 cycles after accept
  - `busy_o` high throughout the frame
- Parity: parity macro defined, data 0x07. Required response:
  - parity bit 1 after data bits 1,1,1,0,0,0,0,0
  - frame length 44 cycles
- Enable gating: ena=0 with valid=1 for 20 cycles → `tx_ready_o`=0, `tx_o` stays 1, no `done_o`.
- Enable drop mid-frame: clear ena at cycle 10 of a frame → the frame completes with a correct `done_o`. No further accept while valid stays high.
- Reset mid-frame: assert `main_rst_i` for 1 cycle at cycle 15 of a frame. Required response:
  - next cycle: `tx_o`=1, `busy_o`=0, `done_o` never pulses
  - a new 0x3C frame afterwards is transmitted correctly
- Back-to-back: valid held high, ena=1, div_p=1, data changed after each accept → consecutive frames with exactly one idle-high cycle between stop and next start. Each frame carries its latched data.
